// File: rtl/mem_burst_reader.sv
// Burst read engine for the packet buffer: turns an (address, length) descriptor into
// sequential registered-port reads and streams the returned words out with a last flag.
module mem_burst_reader #(
   parameter int WIDTH  = 128,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [ADDR_W-1:0] desc_addr,
   input  logic [LEN_W-1:0]  desc_len,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read_en,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [LEN_W-1:0]    remaining_q, remaining_d;
   logic                inflight_q, inflight_last_q;
   logic [WIDTH-1:0]    fifo_data_q [2];
   logic [1:0]          fifo_last_q;
   logic                wr_ptr_q, rd_ptr_q;
   logic [1:0]          count_q;
   logic                issue, push, pop;
   logic [2:0]          credit;

   assign out_valid = (count_q != 2'd0);
   assign pop       = out_valid & out_ready;
   assign push      = inflight_q;

   // Words buffered or in flight after this cycle's pop; keeping it below two
   // before issuing guarantees the two-entry skid buffer can never overflow.
   assign credit = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      remaining_d = remaining_q;
      issue       = 1'b0;
      case (state_q)
         IDLE: begin
            if (desc_valid) begin
               rd_addr_d   = desc_addr;
               remaining_d = desc_len;
               state_d     = READ;
            end
         end
         READ: begin
            if (credit < 3'd2) begin
               issue       = 1'b1;
               rd_addr_d   = rd_addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == '0) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && out_last && (count_q == 2'd1) && !inflight_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= IDLE;
         rd_addr_q       <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         fifo_last_q     <= 2'b00;
         wr_ptr_q        <= 1'b0;
         rd_ptr_q        <= 1'b0;
         count_q         <= 2'd0;
      end else begin
         state_q         <= state_d;
         rd_addr_q       <= rd_addr_d;
         remaining_q     <= remaining_d;
         inflight_q      <= issue;
         inflight_last_q <= issue && (remaining_q == '0);
         if (push) begin
            fifo_last_q[wr_ptr_q] <= inflight_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // Payload storage needs no reset: out_data is masked whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_data_q[wr_ptr_q] <= mem_rdata;
   end

   assign desc_ready  = (state_q == IDLE) & reset_n;
   assign mem_read_en = issue;
   assign mem_addr    = rd_addr_q;
   assign out_data    = out_valid ? fifo_data_q[rd_ptr_q] : '0;
   assign out_last    = out_valid & fifo_last_q[rd_ptr_q];
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: a word-queue model of each burst checked
// every cycle, plus directed bursts with hand-computed expectations.
module tb_mem_burst_reader;

   localparam int WIDTH = 128;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             last;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             desc_valid = 1'b0;
   logic             desc_ready;
   logic [7:0]       desc_addr = 8'h00;
   logic [7:0]       desc_len = 8'h00;
   logic [7:0]       mem_addr;
   logic             mem_read_en;
   logic [WIDTH-1:0] mem_rdata = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             busy;

   logic [WIDTH-1:0] mem [256];
   exp_t             expQ[$];
   logic [7:0]       issueAddrs[$];
   logic [WIDTH-1:0] gotData[$];
   logic             gotLast[$];
   int               acceptWords[$];

   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   logic             active = 1'b0;
   logic [7:0]       expAddr = 8'h00;
   int               issued = 0;
   int               popped = 0;
   logic             holdPrev = 1'b0;
   logic [WIDTH-1:0] holdData = '0;
   int               runLen = 0;
   int               maxRun = 0;
   int               firstIssueCyc = -1;
   int               firstValidCyc = -1;
   int               acceptCyc = -1;
   int               lastPopCyc = -1;

   mem_burst_reader #(.WIDTH(WIDTH), .ADDR_W(8), .LEN_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len),
      .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // Cycle counter used to timestamp observations for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Registered read port of the buffer: data appears the cycle after the strobe.
   always @(posedge clk) begin
      if (mem_read_en) mem_rdata <= mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                              input logic [WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearStats();
      issueAddrs.delete();
      gotData.delete();
      gotLast.delete();
      acceptWords.delete();
      firstIssueCyc = -1;
      firstValidCyc = -1;
      maxRun = 0;
   endtask

   // Model: each accepted descriptor queues its words; outputs are checked on every cycle
   // at the falling edge, where the coming rising-edge handshakes are already decided.
   always @(negedge clk) begin
      if (!reset_n) begin
         expQ.delete();
         active   = 1'b0;
         issued   = 0;
         popped   = 0;
         holdPrev = 1'b0;
         runLen   = 0;
      end else begin
         checkOutput("busy", WIDTH'(busy), WIDTH'(active));
         checkOutput("desc_ready", WIDTH'(desc_ready), WIDTH'(!active));
         if (holdPrev) begin
            checkOutput("hold_valid", WIDTH'(out_valid), WIDTH'(1'b1));
            checkOutput("hold_data", out_data, holdData);
         end
         if (mem_read_en) begin
            checkOutput("read_in_burst", WIDTH'(active), WIDTH'(1'b1));
            checkOutput("mem_addr", WIDTH'(mem_addr), WIDTH'(expAddr));
            expAddr = expAddr + 8'd1;
            issued++;
            issueAddrs.push_back(mem_addr);
            if (firstIssueCyc < 0) firstIssueCyc = cyc;
         end
         if (out_valid) begin
            runLen++;
            if (runLen > maxRun) maxRun = runLen;
            if (firstValidCyc < 0) firstValidCyc = cyc;
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_word: got %h expected no word (cycle %0d)", out_data, cyc);
            end else begin
               checkOutput("out_data", out_data, expQ[0].data);
               checkOutput("out_last", WIDTH'(out_last), WIDTH'(expQ[0].last));
               if (out_ready) begin
                  gotData.push_back(out_data);
                  gotLast.push_back(out_last);
                  popped++;
                  lastPopCyc = cyc;
                  if (expQ[0].last) active = 1'b0;
                  void'(expQ.pop_front());
               end
            end
         end else begin
            runLen = 0;
         end
         checkOutput("credit", WIDTH'((issued - popped) <= 2), WIDTH'(1'b1));
         holdPrev = out_valid && !out_ready;
         holdData = out_data;
         if (desc_valid && desc_ready) begin
            active    = 1'b1;
            expAddr   = desc_addr;
            acceptCyc = cyc;
            acceptWords.push_back(gotData.size());
            for (int i = 0; i <= int'(desc_len); i++) begin
               logic [7:0] a;
               exp_t e;
               a = desc_addr + 8'(i);
               e.data = mem[a];
               e.last = (i == int'(desc_len));
               expQ.push_back(e);
            end
         end
      end
   end

   // Offers one descriptor and runs it to completion; mode 0 keeps out_ready high,
   // mode 1 drives 1,0,0,1 then random backpressure.
   task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] len, input int mode);
      int n;
      clearStats();
      out_ready = 1'b1;
      n = 0;
      while (!desc_ready && n < 50) begin
         tick();
         n++;
      end
      checkOutput("desc_ready_wait", WIDTH'(desc_ready), WIDTH'(1'b1));
      desc_valid = 1'b1;
      desc_addr  = addr;
      desc_len   = len;
      tick();
      desc_valid = 1'b0;
      n = 0;
      while ((busy || expQ.size() != 0) && n < 3000) begin
         if (mode == 0)  out_ready = 1'b1;
         else if (n < 4) out_ready = (n == 0 || n == 3);
         else            out_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      checkOutput("burst_done", WIDTH'(busy), WIDTH'(1'b0));
      out_ready = 1'b1;
   endtask

   initial begin
      int n;
      for (int k = 0; k < 256; k++) begin
         logic [7:0] b;
         b = k[7:0];
         mem[k] = {16{b}};
      end
      for (int k = 0; k < 4; k++) mem[k] = WIDTH'(k);
      mem[8'h10] = {16{8'hAA}};

      #2 reset_n = 1'b0;
      #1;
      checkOutput("rst_desc_ready", WIDTH'(desc_ready), '0);
      checkOutput("rst_mem_read_en", WIDTH'(mem_read_en), '0);
      checkOutput("rst_mem_addr", WIDTH'(mem_addr), '0);
      checkOutput("rst_out_valid", WIDTH'(out_valid), '0);
      checkOutput("rst_out_data", out_data, '0);
      checkOutput("rst_busy", WIDTH'(busy), '0);
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      checkOutput("post_rst_desc_ready", WIDTH'(desc_ready), WIDTH'(1'b1));

      // Single word burst.
      applyStimulus(8'h10, 8'd0, 0);
      checkOutput("single_reads", WIDTH'(issueAddrs.size()), WIDTH'(1));
      if (issueAddrs.size() >= 1) checkOutput("single_addr", WIDTH'(issueAddrs[0]), WIDTH'(8'h10));
      checkOutput("single_words", WIDTH'(gotData.size()), WIDTH'(1));
      if (gotData.size() >= 1) begin
         checkOutput("single_data", gotData[0], {16{8'hAA}});
         checkOutput("single_last", WIDTH'(gotLast[0]), WIDTH'(1'b1));
      end
      checkOutput("single_ready_back", WIDTH'(desc_ready), WIDTH'(1'b1));

      // Full-rate four-word burst.
      applyStimulus(8'h00, 8'd3, 0);
      checkOutput("full_words", WIDTH'(gotData.size()), WIDTH'(4));
      for (int i = 0; i < 4 && i < gotData.size(); i++) begin
         checkOutput("full_data", gotData[i], WIDTH'(i));
         checkOutput("full_last", WIDTH'(gotLast[i]), WIDTH'(i == 3));
      end
      checkOutput("full_issue_latency", WIDTH'(firstIssueCyc - acceptCyc), WIDTH'(1));
      checkOutput("full_data_latency", WIDTH'(firstValidCyc - firstIssueCyc), WIDTH'(2));
      checkOutput("full_no_bubbles", WIDTH'(maxRun), WIDTH'(4));

      // Backpressure.
      applyStimulus(8'h20, 8'd7, 1);
      checkOutput("bp_words", WIDTH'(gotData.size()), WIDTH'(8));
      for (int i = 0; i < 8 && i < gotData.size(); i++) begin
         logic [7:0] b;
         b = 8'h20 + 8'(i);
         checkOutput("bp_data", gotData[i], {16{b}});
      end

      // Address wrap.
      applyStimulus(8'hFE, 8'd3, 0);
      checkOutput("wrap_reads", WIDTH'(issueAddrs.size()), WIDTH'(4));
      if (issueAddrs.size() == 4) begin
         checkOutput("wrap_addr0", WIDTH'(issueAddrs[0]), WIDTH'(8'hFE));
         checkOutput("wrap_addr1", WIDTH'(issueAddrs[1]), WIDTH'(8'hFF));
         checkOutput("wrap_addr2", WIDTH'(issueAddrs[2]), WIDTH'(8'h00));
         checkOutput("wrap_addr3", WIDTH'(issueAddrs[3]), WIDTH'(8'h01));
      end
      if (gotData.size() == 4) begin
         checkOutput("wrap_data0", gotData[0], {16{8'hFE}});
         checkOutput("wrap_data1", gotData[1], {16{8'hFF}});
         checkOutput("wrap_data2", gotData[2], WIDTH'(0));
         checkOutput("wrap_data3", gotData[3], WIDTH'(1));
      end

      // Maximum length burst with a second descriptor held valid throughout.
      clearStats();
      out_ready  = 1'b1;
      desc_valid = 1'b1;
      desc_addr  = 8'h00;
      desc_len   = 8'd255;
      tick();
      desc_addr = 8'h40;
      desc_len  = 8'd2;
      n = 0;
      while (acceptWords.size() < 2 && n < 2000) begin
         tick();
         n++;
      end
      desc_valid = 1'b0;
      checkOutput("b2b_second_accept", WIDTH'(acceptWords.size()), WIDTH'(2));
      if (acceptWords.size() == 2) begin
         checkOutput("b2b_words_before", WIDTH'(acceptWords[1]), WIDTH'(256));
         checkOutput("b2b_accept_gap", WIDTH'(acceptCyc - lastPopCyc), WIDTH'(1));
      end
      if (gotLast.size() >= 256) begin
         checkOutput("max_last", WIDTH'(gotLast[255]), WIDTH'(1'b1));
         checkOutput("max_not_last", WIDTH'(gotLast[254]), WIDTH'(1'b0));
      end
      n = 0;
      while ((busy || expQ.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      checkOutput("b2b_words", WIDTH'(gotData.size()), WIDTH'(259));
      if (gotData.size() == 259) begin
         checkOutput("b2b_data0", gotData[256], {16{8'h40}});
         checkOutput("b2b_data2", gotData[258], {16{8'h42}});
      end

      // Reset in the middle of a six-word burst.
      clearStats();
      desc_valid = 1'b1;
      desc_addr  = 8'h80;
      desc_len   = 8'd5;
      tick();
      desc_valid = 1'b0;
      n = 0;
      while (gotData.size() < 2 && n < 50) begin
         tick();
         n++;
      end
      checkOutput("mid_words_before_reset", WIDTH'(gotData.size()), WIDTH'(2));
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_desc_ready", WIDTH'(desc_ready), '0);
      checkOutput("mid_rst_mem_read_en", WIDTH'(mem_read_en), '0);
      checkOutput("mid_rst_mem_addr", WIDTH'(mem_addr), '0);
      checkOutput("mid_rst_out_valid", WIDTH'(out_valid), '0);
      checkOutput("mid_rst_out_data", out_data, '0);
      checkOutput("mid_rst_out_last", WIDTH'(out_last), '0);
      checkOutput("mid_rst_busy", WIDTH'(busy), '0);
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      checkOutput("mid_post_rst_ready", WIDTH'(desc_ready), WIDTH'(1'b1));
      applyStimulus(8'h90, 8'd1, 0);
      checkOutput("fresh_words", WIDTH'(gotData.size()), WIDTH'(2));
      if (gotData.size() == 2) begin
         checkOutput("fresh_data0", gotData[0], {16{8'h90}});
         checkOutput("fresh_data1", gotData[1], {16{8'h91}});
         checkOutput("fresh_last0", WIDTH'(gotLast[0]), WIDTH'(1'b0));
         checkOutput("fresh_last1", WIDTH'(gotLast[1]), WIDTH'(1'b1));
      end

      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
Egress-side read engine for the switch packet buffer memory. It accepts a burst descriptor (start address and word count) and issues sequential reads to the buffer's registered read port, which returns data one cycle after the read enable. It returns the words on a valid/ready stream with a last-word flag. It sits between the egress scheduler and the output port, and is the read counterpart of the ingress write path into the buffer.

Parameters:
WIDTH, 128, data word width in bits; matches buffer word width.
ADDR_W, 8, buffer address width; buffer depth is 2**ADDR_W.
LEN_W, 8, descriptor length field width.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
desc_valid  in  1  descriptor offered
desc_ready  out  1  engine can accept a descriptor
desc_addr  in  ADDR_W  first word address of burst
desc_len  in  LEN_W  burst length minus one (0 means 1 word, 255 means 256 words)
mem_addr  out  ADDR_W  read address to buffer
mem_read_en  out  1  read strobe to buffer; data returns on mem_rdata next cycle
mem_rdata  in  WIDTH  buffer read data (registered in buffer)
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts word
out_data  out  WIDTH  output word
out_last  out  1  marks final word of burst, qualified by out_valid
busy  out  1  high from descriptor accept until last word is accepted

Behaviour:
- Reset (reset_n low, async): state IDLE; FIFO cleared; in-flight flag cleared.
- Reset output values: desc_ready=0, mem_read_en=0, mem_addr=0, out_valid=0, out_data=0, out_last=0, busy=0.
- desc_ready=1 only in IDLE with reset released.
- States:
  - IDLE: on desc_valid and desc_ready, latch rd_addr=desc_addr and remaining=desc_len. Go to READ and set busy=1.
  - READ: issue reads, one address per cycle when credit allows (see read issue rule). After issuing the read with remaining==0, go to DRAIN.
  - DRAIN: no reads. When FIFO is empty, nothing is in flight, and the last word is handshaken, go to IDLE and set busy=0. desc_ready rises the following cycle.
- Read issue rule:
  - mem_read_en=1 in READ when (fifo_count + inflight - pop) < 2, where pop = out_valid and out_ready this cycle.
  - mem_addr=rd_addr. On issue: rd_addr increments modulo 2**ADDR_W (255 wraps to 0) and remaining decrements.
  - mem_read_en=0 in all other states.
- In-flight tracking:
  - inflight is a 1-bit register set on the cycle after an issue.
  - That cycle, mem_rdata is pushed into the FIFO, together with a last tag (set if it was the final read).
- FIFO:
  - 2-entry skid buffer; must never overflow, and the credit rule guarantees this.
  - out_valid = FIFO not empty. out_data and out_last come from the FIFO head.
  - Head is held stable while out_valid and !out_ready.
- Latency: descriptor handshake at edge E0 gives mem_read_en high in the cycle after E0, and first out_valid two cycles after that.
- Throughput: with out_ready held high, one word per cycle sustained; no bubbles between words of one burst.
- Back-to-back descriptors: a new descriptor is accepted only in IDLE. Bursts never overlap.
- Backpressure: reads stall so that at most 2 words are buffered. No word is dropped or duplicated.
- Reset mid-burst: abandons the burst immediately. Outputs take reset values, and FIFO contents are discarded.
- desc_len=0: a single read with out_last=1 on that word.

Test Plan:
- Single word: preload mem[0x10]=0xAA..AA; descriptor addr=0x10, len=0 -> one mem_read_en at 0x10; one out_valid with out_data=0xAA..AA and out_last=1; desc_ready back high afterwards.
- Full-rate burst: mem[k]=k for k=0..3; addr=0, len=3, out_ready=1 -> out_valid high for 4 consecutive cycles with data 0,1,2,3; out_last only on 3; first out_valid 2 cycles after first mem_read_en.
- Backpressure: addr=0x20, len=7; out_ready toggles 1,0,0,1,... and is randomised -> all 8 words delivered in order exactly once; out_data stable while stalled; at most 2 reads ahead of the accepted count.
- Address wrap: addr=0xFE, len=3 -> mem_addr sequence FE, FF, 00, 01; data matches those locations.
- Max length and back-to-back: len=255 from addr=0, then a second descriptor held valid -> 256 words with out_last on the 256th; second descriptor accepted only after busy falls; no overlap.
- Reset mid-burst: assert reset_n low after 2 of 6 words -> all outputs 0 asynchronously; after release desc_ready=1, and a fresh len=1 burst completes correctly with no stale words.
